// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over request/grant, and
// buffers in-order responses in a 2-entry queue for decode. Define FETCH_PERF_CNT_EN for perf counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  outstanding_next;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        q_rd;
  logic        q_wr;
  logic [31:0] tag_pc  [2];
  logic        tag_rd;
  logic        tag_wr;
  logic [31:0] last_pc;
  logic        grant;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^PCTargetE[1:0];

  // NOTE: every always_comb output is assigned a default before any branch, so no latch is inferred.
  always_comb begin
    ValidD           = (count != 2'd0);
    pop              = ValidD && !StallD && !PCSrcE;
    occupancy        = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
    IMemReq          = !rst && (occupancy < 3'd2);
    IMemAddr         = pc;
    grant            = IMemReq && IMemGnt;
    push             = IMemRspValid && (drop == 2'd0) && !PCSrcE;
    outstanding_next = outstanding + {1'b0, grant} - {1'b0, IMemRspValid};
    InstrD           = NOP_INSTR;
    PCD              = last_pc;
    if (ValidD) begin
      InstrD = q_instr[q_rd];
      PCD    = q_pc[q_rd];
    end
    PCPlus4D = PCD + 32'd4;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
      q_rd        <= 1'b0;
      q_wr        <= 1'b0;
      tag_rd      <= 1'b0;
      tag_wr      <= 1'b0;
      last_pc     <= RESET_PC;
    end else begin
      outstanding <= outstanding_next;
      if (grant)        tag_wr  <= ~tag_wr;
      if (IMemRspValid) tag_rd  <= ~tag_rd;
      if (ValidD)       last_pc <= q_pc[q_rd];
      if (PCSrcE) begin
        // Everything still in flight, including this cycle's grant, belongs to the old path.
        pc    <= {PCTargetE[31:2], 2'b00};
        drop  <= outstanding_next;
        count <= 2'd0;
        q_rd  <= q_wr;
      end else begin
        if (grant)                           pc   <= pc + 32'd4;
        if (IMemRspValid && drop != 2'd0)    drop <= drop - 2'd1;
        if (push)                            q_wr <= ~q_wr;
        if (pop)                             q_rd <= ~q_rd;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: storage arrays carry no reset; their contents are only read behind count/outstanding.
  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr] <= pc;
    if (push) begin
      q_instr[q_wr] <= IMemRspData;
      q_pc[q_wr]    <= tag_pc[tag_rd];
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FetchCount  <= 32'd0;
      BubbleCount <= 32'd0;
    end else begin
      if (pop)     FetchCount  <= FetchCount + 32'd1;
      if (!ValidD) BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle stimulus table drives a latency-configurable
// memory model; a monitor pops a queue of hand-listed expected deliveries and compares.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req, gnt, rsp_valid, stall, pcsrc, valid;
  logic [31:0] addr, rsp_data, target, instr, pcd, pcp4;
  logic        req2, rsp2_valid, valid2;
  logic [31:0] addr2, rsp2_data, instr2, pcd2, pcp4_2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int mc     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic        pend2_v = 1'b0;
  logic [31:0] pend2_a = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .IMemReq(req), .IMemAddr(addr), .IMemGnt(gnt),
    .IMemRspValid(rsp_valid), .IMemRspData(rsp_data),
    .StallD(stall), .PCSrcE(pcsrc), .PCTargetE(target),
    .ValidD(valid), .InstrD(instr), .PCD(pcd), .PCPlus4D(pcp4)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(fetch_cnt), .BubbleCount(bubble_cnt)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .IMemReq(req2), .IMemAddr(addr2), .IMemGnt(1'b1),
    .IMemRspValid(rsp2_valid), .IMemRspData(rsp2_data),
    .StallD(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .ValidD(valid2), .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pcp4_2)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(fetch_cnt2), .BubbleCount(bubble_cnt2)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[26:2], 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory: records grants at the clock edge, answers each one `lat` cycles later at the falling edge.
  always @(posedge clk) begin
    if (rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      pend2_v <= 1'b0;
    end else begin
      if (req && gnt) begin
        mem_addr_q.push_back(addr);
        mem_due_q.push_back(mc + lat);
      end
      pend2_v <= req2;
      pend2_a <= addr2;
    end
    mc <= mc + 1;
  end

  always @(negedge clk) begin
    if (!rst && mem_due_q.size() > 0 && mem_due_q[0] == mc) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'hBAD0_BAD0;
    end
    rsp2_valid = pend2_v && !rst;
    rsp2_data  = instr_of(pend2_a);
  end

  // Scoreboard monitor: every instruction decode accepts must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (!rst && valid && !stall && !pcsrc) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", pcd, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("deliver_pcd", pcd, e);
        check("deliver_instr", instr, instr_of(e));
        check("deliver_pcplus4", pcp4, e + 32'd4);
      end
    end
  end

  initial begin
    gnt = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = 32'h0;
    for (int a = 0; a <= 40; a += 4) exp_q.push_back(32'(a));
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    for (int a = 32'h200; a <= 32'h214; a += 4) exp_q.push_back(32'(a));

    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rst    = (k < 3) || (k >= 48);
      gnt    = (k < 18) || (k >= 21 && k < 28) || (k >= 32 && k < 40) || (k >= 44 && k < 47);
      stall  = (k >= 11 && k <= 14) || (k >= 44 && k <= 47);
      pcsrc  = (k == 23) || (k == 33);
      target = (k == 23) ? 32'h0000_0103 : (k == 33) ? 32'h0000_0201 : 32'hDEAD_BEEF;
      lat    = (k >= 20 && k < 31) ? 2 : 1;
      #1;
      case (k)
        2: begin
          check("reset_req", {31'b0, req}, 32'd0);
          check("reset_valid", {31'b0, valid}, 32'd0);
          check("reset_instr_nop", instr, NOP);
          check("reset_pcd", pcd, 32'h0);
          check("reset_pcplus4", pcp4, 32'h4);
          check("wrap_reset_req", {31'b0, req2}, 32'd0);
          check("wrap_reset_pcd", pcd2, 32'hFFFF_FFF8);
          check("wrap_reset_pcplus4", pcp4_2, 32'hFFFF_FFFC);
        end
        3: begin
          check("first_req", {31'b0, req}, 32'd1);
          check("first_addr", addr, 32'h0);
          check("first_valid_low", {31'b0, valid}, 32'd0);
          check("wrap_addr0", addr2, 32'hFFFF_FFF8);
        end
        4: begin
          check("lat_valid_low", {31'b0, valid}, 32'd0);
          check("second_addr", addr, 32'h4);
          check("wrap_addr1", addr2, 32'hFFFF_FFFC);
        end
        5: begin
          check("first_valid_high", {31'b0, valid}, 32'd1);
          check("wrap_addr2", addr2, 32'h0);
          check("wrap_first_pcd", pcd2, 32'hFFFF_FFF8);
          check("wrap_first_pcplus4", pcp4_2, 32'hFFFF_FFFC);
        end
        6: begin
          check("wrap_second_pcd", pcd2, 32'hFFFF_FFFC);
          check("wrap_second_pcplus4", pcp4_2, 32'h0);
          check("wrap_second_instr", instr2, instr_of(32'hFFFF_FFFC));
        end
        11, 12, 13, 14: begin
          check("stall_req_low", {31'b0, req}, 32'd0);
          check("stall_pcd_frozen", pcd, 32'h18);
          check("stall_instr_frozen", instr, instr_of(32'h18));
        end
        15: begin
          check("release_req", {31'b0, req}, 32'd1);
          check("release_addr", addr, 32'h20);
        end
`ifdef FETCH_PERF_CNT_EN
        20: begin
          check("perf_fetch", fetch_cnt, 32'd11);
          check("perf_bubble", bubble_cnt, 32'd2);
        end
`endif
        23: begin
          check("two_outstanding_req_low", {31'b0, req}, 32'd0);
          check("redirect_valid_low", {31'b0, valid}, 32'd0);
        end
        24: begin
          check("redirect_addr", addr, 32'h100);
          check("redirect_req", {31'b0, req}, 32'd1);
          check("after_redirect_valid", {31'b0, valid}, 32'd0);
        end
        34: begin
          check("redirect2_addr", addr, 32'h200);
          check("redirect2_queue_empty", {31'b0, valid}, 32'd0);
        end
        35: check("redirect2_drop_valid", {31'b0, valid}, 32'd0);
        44: check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        47: begin
          check("pre_reset_valid", {31'b0, valid}, 32'd1);
          check("pre_reset_pcd", pcd, 32'h218);
          #1 rst = 1'b1;
          #1;
          check("midreset_valid", {31'b0, valid}, 32'd0);
          check("midreset_req", {31'b0, req}, 32'd0);
          check("midreset_instr", instr, NOP);
          check("midreset_pcd", pcd, 32'h0);
          check("midreset_pcplus4", pcp4, 32'h4);
        end
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
